instr_ram_loader: RTL
=====================

INSTR_RAM_LOADER -- requirements
Module: instr_ram_loader

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 15: byte-address width of the RAM port.
REQ-002 SHALL have parameter BASE_ADDR, default 0: word-aligned start byte address of the load.
REQ-003 SHALL have port clk, input, 1, the single clock; all logic is on its rising edge.
REQ-004 SHALL have port rst_i, input, 1, asynchronous active-high reset.
REQ-005 SHALL have ports start_i (in, 1, load request) and len_i (in, ADDR_WIDTH, image length in bytes, sampled with start_i).
REQ-006 SHALL have byte-stream sink ports s_valid_i (in, 1), s_data_i (in, 8) and s_ready_o (out, 1).
REQ-007 SHALL have RAM-initiator ports ram_en_o (out, 1), ram_addr_o (out, ADDR_WIDTH, byte address), ram_wdata_o (out, 32), ram_we_o (out, 1), ram_be_o (out, 4) and ram_rdata_i (in, 32, valid one cycle after a read).
REQ-008 SHALL have status ports busy_o (out, 1), done_o (out, 1, one-cycle pulse), err_o (out, 1, sticky) and checksum_o (out, 32).

Function
REQ-009 SHALL implement states IDLE, LOAD, WRITE, VERIFY, DONE.
REQ-010 SHALL move IDLE->LOAD on start_i with len_i != 0, latching len_i, clearing checksum_o and err_o, and setting the address to BASE_ADDR.
REQ-011 SHALL move IDLE->DONE on start_i with len_i == 0, with no RAM access.
REQ-012 SHALL ignore start_i outside IDLE.
REQ-013 SHALL assert s_ready_o only in LOAD; a byte is accepted when s_valid_i && s_ready_o.
REQ-014 SHALL pack accepted bytes little-endian: the nth byte of a word goes to lane n mod 4.
REQ-015 SHALL enter WRITE when the 4th byte of a word, or the final byte of len_i, is accepted.
REQ-016 SHALL keep WRITE exactly one cycle with ram_en_o=1, ram_we_o=1, ram_be_o equal to the filled lanes (partial only on the final word), and unfilled lanes of ram_wdata_o zero.
REQ-017 SHALL, in WRITE, add the byte-masked word to checksum_o (mod 2^32) and advance the address by 4, wrapping mod 2^ADDR_WIDTH.
REQ-018 SHALL return from WRITE to LOAD if bytes remain, otherwise go to VERIFY (macro defined) or DONE.
REQ-019 SHALL hold ram_addr_o[1:0] at 0 and drive ram_en_o, ram_we_o and ram_be_o to 0 whenever no access is issued.
REQ-020 SHALL pulse done_o for one cycle in DONE, then return to IDLE.
REQ-021 SHALL hold busy_o=1 in every state except IDLE.
REQ-022 SHALL NOT drop, duplicate or reorder bytes under any s_valid_i stall pattern.

Reset
REQ-023 SHALL, on rst_i (also when asserted mid-operation), go to IDLE and drive s_ready_o, ram_en_o, ram_we_o, ram_be_o, busy_o, done_o and err_o to 0, and ram_addr_o, ram_wdata_o and checksum_o to 0.
REQ-024 SHALL NOT produce a partial RAM write as a result of reset.

Configuration
REQ-025 SHALL include, when macro INSTR_LOADER_VERIFY_EN is defined, VERIFY: issue one read per cycle (ram_en_o=1, ram_we_o=0, ram_be_o=4'hF) from BASE_ADDR over all written words.
REQ-026 SHALL, in VERIFY, accumulate each ram_rdata_i one cycle after its read, masked like the original write.
REQ-027 SHALL, in VERIFY, set err_o if the recomputed sum differs from checksum_o, and enter DONE after the last read data arrives.
REQ-028 SHALL, without INSTR_LOADER_VERIFY_EN, contain no VERIFY state or logic and keep err_o at 0.

Verification
REQ-029 SHALL test: len_i=8, bytes 01..08 streamed back to back -> writes 32'h04030201 at addr 0 and 32'h08070605 at addr 4, be=4'hF each, checksum_o=32'h0C0A0806, one done_o pulse.
REQ-030 SHALL test: len_i=5, bytes AA BB CC DD EE -> second write 32'h000000EE at addr 4 with be=4'b0001.
REQ-031 SHALL test: len_i=0 -> done_o one cycle after start_i, no ram_en_o.
REQ-032 SHALL test: random s_valid_i gaps, len_i=64 -> RAM contents match the stream, 16 writes.
REQ-033 SHALL test: rst_i asserted after 3 of 8 bytes -> all outputs 0 the same cycle, no write; a new start_i loads correctly.
REQ-034 SHALL test: with INSTR_LOADER_VERIFY_EN, the RAM model corrupts the word at addr 4 -> err_o=1 with done_o; with no corruption err_o=0.

Source files
------------

// File: rtl/instr_ram_loader.sv
// instr_ram_loader: receives a byte stream, packs it little-endian into
// 32-bit words, writes them to an instruction RAM from BASE_ADDR on, and
// keeps a running 32-bit sum of the written (byte-masked) words.
// Optional feature macro: INSTR_LOADER_VERIFY_EN adds a read-back pass that
// recomputes the sum from RAM and raises err_o on a difference.
// Stream handshake: a byte moves when s_valid_i && s_ready_o are both high at
// a rising clk edge; s_ready_o does not depend on s_valid_i.
// state_o exposes the FSM state (0 IDLE, 1 LOAD, 2 WRITE, 3 VERIFY, 4 DONE).
module instr_ram_loader #(
    parameter int                    ADDR_WIDTH = 15,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
    input  logic                  clk,
    input  logic                  rst_i,
    input  logic                  start_i,
    input  logic [ADDR_WIDTH-1:0] len_i,
    input  logic                  s_valid_i,
    input  logic [7:0]            s_data_i,
    output logic                  s_ready_o,
    output logic                  ram_en_o,
    output logic [ADDR_WIDTH-1:0] ram_addr_o,
    output logic [31:0]           ram_wdata_o,
    output logic                  ram_we_o,
    output logic [3:0]            ram_be_o,
    input  logic [31:0]           ram_rdata_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  err_o,
    output logic [31:0]           checksum_o,
    output logic [2:0]            state_o
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
        S_WRITE  = 3'd2,
`ifdef INSTR_LOADER_VERIFY_EN
        S_VERIFY = 3'd3,
`endif
        S_DONE   = 3'd4
    } state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] len_q;       // bytes still to be accepted
    logic [1:0]            lane_q;      // next byte lane of the word being filled
    logic [31:0]           word_q;      // word being filled, unfilled lanes zero
    logic [3:0]            be_q;        // lanes filled so far
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [31:0]           checksum_q;
    logic                  err_q;
    logic                  last_byte;

    assign last_byte = (lane_q == 2'd3) || (len_q == ADDR_WIDTH'(1));

`ifdef INSTR_LOADER_VERIFY_EN
    logic [ADDR_WIDTH-1:0] nwords_q;    // words written by this load
    logic [3:0]            last_be_q;   // lane mask of the final written word
    logic [ADDR_WIDTH-1:0] rd_cnt_q;    // reads issued so far
    logic                  pend_q;      // read data arrives this cycle
    logic                  pend_last_q; // ... and it is the final word
    logic [3:0]            pend_be_q;   // lane mask applied to that data
    logic [31:0]           vsum_q;
    logic [31:0]           vsum_next;
    logic                  rd_issue;

    function automatic logic [31:0] lane_mask(input logic [3:0] be);
        return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    endfunction

    assign rd_issue  = (state_q == S_VERIFY) && (rd_cnt_q != nwords_q);
    assign vsum_next = vsum_q + (ram_rdata_i & lane_mask(pend_be_q));
`else
    logic unused_rdata;
    assign unused_rdata = ^ram_rdata_i;
`endif

    // State register.
    always_ff @(posedge clk or posedge rst_i) begin
        if (rst_i) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    // Next-state decode and RAM/stream/status outputs.
    always_comb begin
        state_d     = state_q;
        s_ready_o   = 1'b0;
        ram_en_o    = 1'b0;
        ram_we_o    = 1'b0;
        ram_be_o    = 4'h0;
        ram_addr_o  = '0;
        ram_wdata_o = 32'h0;
        done_o      = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start_i) state_d = (len_i != '0) ? S_LOAD : S_DONE;
            end
            S_LOAD: begin
                s_ready_o = 1'b1;
                if (s_valid_i && last_byte) state_d = S_WRITE;
            end
            S_WRITE: begin
                ram_en_o    = 1'b1;
                ram_we_o    = 1'b1;
                ram_be_o    = be_q;
                ram_addr_o  = addr_q;
                ram_wdata_o = word_q;
`ifdef INSTR_LOADER_VERIFY_EN
                state_d = (len_q == '0) ? S_VERIFY : S_LOAD;
`else
                state_d = (len_q == '0) ? S_DONE : S_LOAD;
`endif
            end
`ifdef INSTR_LOADER_VERIFY_EN
            S_VERIFY: begin
                if (rd_issue) begin
                    ram_en_o   = 1'b1;
                    ram_be_o   = 4'hF;
                    ram_addr_o = addr_q;
                end
                if (pend_q && pend_last_q) state_d = S_DONE;
            end
`endif
            S_DONE: begin
                done_o  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Byte packing, address stepping, checksum and read-back accumulation.
    always_ff @(posedge clk or posedge rst_i) begin
        if (rst_i) begin
            len_q       <= '0;
            lane_q      <= 2'd0;
            word_q      <= 32'h0;
            be_q        <= 4'h0;
            addr_q      <= '0;
            checksum_q  <= 32'h0;
            err_q       <= 1'b0;
`ifdef INSTR_LOADER_VERIFY_EN
            nwords_q    <= '0;
            last_be_q   <= 4'h0;
            rd_cnt_q    <= '0;
            pend_q      <= 1'b0;
            pend_last_q <= 1'b0;
            pend_be_q   <= 4'h0;
            vsum_q      <= 32'h0;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start_i && len_i != '0) begin
                        len_q      <= len_i;
                        lane_q     <= 2'd0;
                        word_q     <= 32'h0;
                        be_q       <= 4'h0;
                        addr_q     <= BASE_ADDR;
                        checksum_q <= 32'h0;
                        err_q      <= 1'b0;
`ifdef INSTR_LOADER_VERIFY_EN
                        nwords_q   <= '0;
`endif
                    end
                end
                S_LOAD: begin
                    if (s_valid_i) begin
                        word_q[{lane_q, 3'b000} +: 8] <= s_data_i;
                        be_q[lane_q]                  <= 1'b1;
                        lane_q                        <= lane_q + 2'd1;
                        len_q                         <= len_q - ADDR_WIDTH'(1);
                    end
                end
                S_WRITE: begin
                    checksum_q <= checksum_q + word_q;
                    word_q     <= 32'h0;
                    be_q       <= 4'h0;
                    lane_q     <= 2'd0;
`ifdef INSTR_LOADER_VERIFY_EN
                    nwords_q   <= nwords_q + ADDR_WIDTH'(1);
                    last_be_q  <= be_q;
                    rd_cnt_q   <= '0;
                    pend_q     <= 1'b0;
                    vsum_q     <= 32'h0;
                    // Read-back starts over from the first written word.
                    addr_q     <= (len_q == '0) ? BASE_ADDR : addr_q + ADDR_WIDTH'(4);
`else
                    addr_q     <= addr_q + ADDR_WIDTH'(4);
`endif
                end
`ifdef INSTR_LOADER_VERIFY_EN
                S_VERIFY: begin
                    pend_q <= rd_issue;
                    if (rd_issue) begin
                        addr_q      <= addr_q + ADDR_WIDTH'(4);
                        rd_cnt_q    <= rd_cnt_q + ADDR_WIDTH'(1);
                        pend_last_q <= (rd_cnt_q + ADDR_WIDTH'(1)) == nwords_q;
                        pend_be_q   <= ((rd_cnt_q + ADDR_WIDTH'(1)) == nwords_q) ? last_be_q : 4'hF;
                    end
                    if (pend_q) begin
                        vsum_q <= vsum_next;
                        if (pend_last_q && vsum_next != checksum_q) err_q <= 1'b1;
                    end
                end
`endif
                default: ;
            endcase
        end
    end

    assign busy_o     = (state_q != S_IDLE);
    assign err_o      = err_q;
    assign checksum_o = checksum_q;
    assign state_o    = state_q;

endmodule
